mem_stage: RTL

- Memory-access stage, directly downstream of the execute stage.
- Consumes the EX/MEM register bundle and runs the data-memory request/grant/response handshake for loads and stores.
- Aligns store data and byte enables; extracts and sign/zero-extends load data.
- Drives the registered MEM/WB bundle, and stalls the pipeline while a memory transaction is outstanding.

---
 rtl/mem_stage.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: dmem request/grant/response handshake, store lane
// alignment, load extraction and the registered MEM/WB bundle. Optional stall counter: MEM_PERF_CNT_EN.
package mem_stage_pkg;
  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } wb_ctrl_t;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
  } mem_ctrl_t;

  typedef struct packed {
    logic [63:0] alu_out;
    logic [31:0] read_data2;
    logic [4:0]  inst_rd;
    wb_ctrl_t    wb_ctrl;
    mem_ctrl_t   mem_ctrl;
  } ex_mem_regs_t;

  typedef struct packed {
    logic [63:0] alu_out;
    logic [31:0] mem_data;
    logic [4:0]  inst_rd;
    wb_ctrl_t    wb_ctrl;
  } mem_wb_regs_t;
endpackage

module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int CNT_W          = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  ex_mem_regs_t i_ex_mem_regs,
  input  logic         i_valid,
  output logic         o_stall,
  output logic         o_dmem_req,
  output logic         o_dmem_we,
  output logic [31:0]  o_dmem_addr,
  output logic [31:0]  o_dmem_wdata,
  output logic [3:0]   o_dmem_be,
  input  logic         i_dmem_gnt,
  input  logic         i_dmem_rvalid,
  input  logic [31:0]  i_dmem_rdata,
  output mem_wb_regs_t o_mem_wb_regs,
  output logic         o_wb_valid,
  output logic         o_misalign,
  output logic         o_timeout
`ifdef MEM_PERF_CNT_EN
  ,
  output logic [31:0]  o_stall_cycles
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_e;

  state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic         req_q, we_q;
  logic [31:0]  addr_q, wdata_q;
  logic [3:0]   be_q;
  mem_wb_regs_t mem_wb_q;
  logic         wb_valid_q, misalign_q, timeout_q;

  logic         memop, misalign, start, time_up, done_ok, abort, stall, load_ok;
  logic [1:0]   addr_lo, size;
  logic         uns;
  logic [31:0]  wdata_d, mem_data_d, ld_data;
  logic [3:0]   be_d;
  logic [7:0]   ld_byte;
  logic [15:0]  ld_half;

  assign addr_lo  = i_ex_mem_regs.alu_out[1:0];
  assign size     = i_ex_mem_regs.mem_ctrl.mem_size;
  assign uns      = i_ex_mem_regs.mem_ctrl.mem_unsigned;
  assign memop    = i_valid & (i_ex_mem_regs.mem_ctrl.mem_read | i_ex_mem_regs.mem_ctrl.mem_write);
  assign misalign = (state_q == IDLE) & memop &
                    (((size == 2'd1) & addr_lo[0]) | ((size == 2'd2) & (addr_lo != 2'b00)));
  assign start    = (state_q == IDLE) & memop & ~misalign;
  assign time_up  = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // A real completion in the last allowed cycle wins over the timeout abort.
  always_comb begin
    done_ok = 1'b0;
    abort   = 1'b0;
    case (state_q)
      REQ: begin
        if (i_dmem_gnt && we_q) done_ok = 1'b1;
        else if (time_up)       abort   = 1'b1;
      end
      WAIT_RSP: begin
        if (i_dmem_rvalid) done_ok = 1'b1;
        else if (time_up)  abort   = 1'b1;
      end
      default: ;
    endcase
  end

  assign stall   = (state_q == IDLE) ? start : ~(done_ok | abort);
  assign load_ok = done_ok & (state_q == WAIT_RSP);

  always_comb begin
    wdata_d = i_ex_mem_regs.read_data2;
    be_d    = 4'b1111;
    case (size)
      2'd0: begin
        wdata_d = {4{i_ex_mem_regs.read_data2[7:0]}};
        be_d    = 4'b0001 << addr_lo;
      end
      2'd1: begin
        wdata_d = {2{i_ex_mem_regs.read_data2[15:0]}};
        be_d    = addr_lo[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = i_dmem_rdata[7:0];
    case (addr_lo)
      2'd1:    ld_byte = i_dmem_rdata[15:8];
      2'd2:    ld_byte = i_dmem_rdata[23:16];
      2'd3:    ld_byte = i_dmem_rdata[31:24];
      default: ;
    endcase
  end

  assign ld_half = addr_lo[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];

  always_comb begin
    ld_data = i_dmem_rdata;
    case (size)
      2'd0:    ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
      2'd1:    ld_data = {{16{~uns & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

  assign mem_data_d = load_ok ? ld_data : 32'h0;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= '0;
      mem_wb_q   <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      misalign_q <= misalign;
      timeout_q  <= abort;
      wb_valid_q <= i_valid & ~stall;
      if (i_valid && !stall) begin
        mem_wb_q.alu_out              <= i_ex_mem_regs.alu_out;
        mem_wb_q.mem_data             <= mem_data_d;
        mem_wb_q.inst_rd              <= i_ex_mem_regs.inst_rd;
        mem_wb_q.wb_ctrl.mem_to_reg   <= i_ex_mem_regs.wb_ctrl.mem_to_reg;
        mem_wb_q.wb_ctrl.reg_write    <= i_ex_mem_regs.wb_ctrl.reg_write & ~misalign & ~abort;
      end
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= REQ;
            cnt_q   <= '0;
            req_q   <= 1'b1;
            we_q    <= i_ex_mem_regs.mem_ctrl.mem_write;
            addr_q  <= {i_ex_mem_regs.alu_out[31:2], 2'b00};
            wdata_q <= wdata_d;
            be_q    <= be_d;
          end
        end
        REQ: begin
          if (done_ok || abort) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
            if (i_dmem_gnt) begin
              state_q <= WAIT_RSP;
              req_q   <= 1'b0;
            end
          end
        end
        WAIT_RSP: begin
          if (done_ok || abort) state_q <= IDLE;
          else                  cnt_q   <= cnt_q + CNT_W'(1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_stall       = stall;
  assign o_dmem_req    = req_q;
  assign o_dmem_we     = we_q;
  assign o_dmem_addr   = addr_q;
  assign o_dmem_wdata  = wdata_q;
  assign o_dmem_be     = be_q;
  assign o_mem_wb_regs = mem_wb_q;
  assign o_wb_valid    = wb_valid_q;
  assign o_misalign    = misalign_q;
  assign o_timeout     = timeout_q;

`ifdef MEM_PERF_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                               stall_cnt_q <= '0;
    else if (stall && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_q <= stall_cnt_q + 32'd1;
  end

  assign o_stall_cycles = stall_cnt_q;
`endif

endmodule
